// File: rtl/delay_timer_pkg.sv
// Shared unit codes, unit-to-milliseconds table and channel state type for the multi-channel delay timer.
package delay_timer_pkg;

  localparam logic [2:0] UNIT_MS  = 3'b000;
  localparam logic [2:0] UNIT_S   = 3'b001;
  localparam logic [2:0] UNIT_MIN = 3'b010;
  localparam logic [2:0] UNIT_HR  = 3'b011;
  localparam logic [2:0] UNIT_DAY = 3'b100;

  // Wide enough for one day in milliseconds minus one.
  localparam int MS_W = 27;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  function automatic logic unit_valid(input logic [2:0] code);
    return (code <= UNIT_DAY);
  endfunction

  function automatic logic [MS_W-1:0] unit_to_ms(input logic [2:0] code);
    logic [MS_W-1:0] ms;
    case (code)
      UNIT_MS:  ms = MS_W'(1);
      UNIT_S:   ms = MS_W'(1000);
      UNIT_MIN: ms = MS_W'(60000);
      UNIT_HR:  ms = MS_W'(3600000);
      UNIT_DAY: ms = MS_W'(86400000);
      default:  ms = '0;
    endcase
    return ms;
  endfunction

endpackage

// File: rtl/delay_timer_multi_if.sv
// Request/status bundle between the sequencer and the multi-channel delay timer.
interface delay_timer_multi_if #(
  parameter int NUM_CH  = 4,
  parameter int DELAY_W = 6
);

  logic [NUM_CH-1:0]         start;
  logic [NUM_CH-1:0]         abort;
  logic                      pause;
  logic [NUM_CH*DELAY_W-1:0] delay;
  logic [NUM_CH*3-1:0]       unit;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         done;
  logic [NUM_CH-1:0]         err;

  modport master (
    output start, abort, pause, delay, unit,
    input  busy, done, err
  );

  modport slave (
    input  start, abort, pause, delay, unit,
    output busy, done, err
  );

endinterface

// File: rtl/delay_timer_channel.sv
// One timer channel: IDLE/RUN FSM over a cycle -> millisecond -> delay down-counter cascade.
// The remaining time is held in mixed radix, so D*U*TICKS_PER_MS is never formed.
module delay_timer_channel
  import delay_timer_pkg::*;
#(
  parameter int DELAY_W      = 6,
  parameter int TICKS_PER_MS = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               pause_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic [2:0]         unit_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int              CYC_W   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(TICKS_PER_MS - 1);

  ch_state_e          state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [MS_W-1:0]    ms_q, ms_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [2:0]         unit_q, unit_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               start_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      ms_q    <= '0;
      dly_q   <= '0;
      unit_q  <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ms_q    <= ms_d;
      dly_q   <= dly_d;
      unit_q  <= unit_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    ms_d     = ms_q;
    dly_d    = dly_q;
    unit_d   = unit_q;
    zero_d   = 1'b0;
    start_ok = start_i && !abort_i && unit_valid(unit_i);
    // Abort suppresses both a pending zero-delay completion and an invalid-unit error.
    done_d   = zero_q && !abort_i;
    err_d    = start_i && !abort_i && !unit_valid(unit_i);

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          if (delay_i == '0) begin
            zero_d = 1'b1;
          end else begin
            state_d = RUN;
            cyc_d   = CYC_MAX;
            ms_d    = unit_to_ms(unit_i) - MS_W'(1);
            dly_d   = delay_i - DELAY_W'(1);
            unit_d  = unit_i;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          cyc_d   = '0;
          ms_d    = '0;
          dly_d   = '0;
        end else if (!pause_i) begin
          if (cyc_q == '0 && ms_q == '0 && dly_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (cyc_q != '0) begin
            cyc_d = cyc_q - CYC_W'(1);
          end else begin
            cyc_d = CYC_MAX;
            if (ms_q != '0) begin
              ms_d = ms_q - MS_W'(1);
            end else begin
              ms_d  = unit_to_ms(unit_q) - MS_W'(1);
              dly_d = dly_q - DELAY_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == RUN);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: rtl/delay_timer_multi.sv
// Multi-channel delay timer: NUM_CH independent channels sharing clock, reset and a global pause.
module delay_timer_multi
  import delay_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DELAY_W      = 6,
  parameter int TICKS_PER_MS = 100000
) (
  input logic               clk,
  input logic               rst,
  delay_timer_multi_if.slave tmr_if
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    delay_timer_channel #(
      .DELAY_W     (DELAY_W),
      .TICKS_PER_MS(TICKS_PER_MS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .start_i(tmr_if.start[i]),
      .abort_i(tmr_if.abort[i]),
      .pause_i(tmr_if.pause),
      .delay_i(tmr_if.delay[i*DELAY_W +: DELAY_W]),
      .unit_i (tmr_if.unit[i*3 +: 3]),
      .busy_o (tmr_if.busy[i]),
      .done_o (tmr_if.done[i]),
      .err_o  (tmr_if.err[i])
    );
  end

endmodule

// File: tb/tb_delay_timer_multi.sv
// Bench for delay_timer_multi: directed scenarios plus random traffic, checked every cycle against a remaining-cycles model.
module tb_delay_timer_multi;

  localparam int NUM_CH = 4;
  localparam int DW     = 6;
  localparam int TPMS   = 4;

  logic clk = 1'b0;
  logic rst;

  delay_timer_multi_if #(.NUM_CH(NUM_CH), .DELAY_W(DW)) tif ();

  delay_timer_multi #(
    .NUM_CH      (NUM_CH),
    .DELAY_W     (DW),
    .TICKS_PER_MS(TPMS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tmr_if(tif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // Model: a running channel holds the number of counting edges still owed.
  logic   m_run  [NUM_CH];
  longint m_rem  [NUM_CH];
  logic   m_zero [NUM_CH];
  logic [NUM_CH-1:0] exp_busy, exp_done, exp_err;

  int last_done_edge [NUM_CH];
  int done_cnt       [NUM_CH];

  function automatic longint ms_per_unit(input logic [2:0] u);
    case (u)
      3'd0: return 1;
      3'd1: return 1000;
      3'd2: return 60000;
      3'd3: return 3600000;
      3'd4: return 86400000;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic model_step();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      logic [DW-1:0] d;
      logic [2:0]    u;
      logic          st, ab, valid, nd, ne;
      d     = tif.delay[ch*DW +: DW];
      u     = tif.unit[ch*3 +: 3];
      st    = tif.start[ch];
      ab    = tif.abort[ch];
      valid = (ms_per_unit(u) != 0);
      nd    = 1'b0;
      ne    = st && !ab && !valid;
      if (rst) begin
        m_run[ch]  = 1'b0;
        m_rem[ch]  = 0;
        m_zero[ch] = 1'b0;
        ne         = 1'b0;
      end else begin
        if (m_zero[ch] && !ab) nd = 1'b1;
        m_zero[ch] = 1'b0;
        if (m_run[ch]) begin
          if (ab) begin
            m_run[ch] = 1'b0;
          end else if (!tif.pause) begin
            m_rem[ch] = m_rem[ch] - 1;
            if (m_rem[ch] == 0) begin
              m_run[ch] = 1'b0;
              nd        = 1'b1;
            end
          end
        end else if (st && !ab && valid) begin
          if (d == '0) begin
            m_zero[ch] = 1'b1;
          end else begin
            m_run[ch] = 1'b1;
            m_rem[ch] = longint'(d) * ms_per_unit(u) * TPMS;
          end
        end
      end
      exp_busy[ch] = m_run[ch];
      exp_done[ch] = nd;
      exp_err[ch]  = ne;
    end
  endtask

  task automatic compare();
    chk("busy", longint'(tif.busy), longint'(exp_busy));
    chk("done", longint'(tif.done), longint'(exp_done));
    chk("err",  longint'(tif.err),  longint'(exp_err));
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (tif.done[ch] === 1'b1) begin
        last_done_edge[ch] = edge_no;
        done_cnt[ch]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_ch(input int ch, input int d, input int u);
    tif.delay[ch*DW +: DW] = DW'(d);
    tif.unit[ch*3 +: 3]    = 3'(u);
  endtask

  // Drives a one-cycle start; on return edge_no is the sampling edge.
  task automatic start_ch(input int ch, input int d, input int u);
    set_ch(ch, d, u);
    tif.start[ch] = 1'b1;
    tick();
    tif.start[ch] = 1'b0;
  endtask

  int s, s2, dc0, dc1, dc2, dc3;

  initial begin
    rst       = 1'b1;
    tif.start = '0;
    tif.abort = '0;
    tif.pause = 1'b0;
    tif.delay = '0;
    tif.unit  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_run[ch] = 1'b0; m_rem[ch] = 0; m_zero[ch] = 1'b0;
      last_done_edge[ch] = -1; done_cnt[ch] = 0;
    end
    exp_busy = '0; exp_done = '0; exp_err = '0;

    run(3);
    chk("reset_busy", longint'(tif.busy), 0);
    chk("reset_done", longint'(tif.done), 0);
    chk("reset_err",  longint'(tif.err),  0);
    rst = 1'b0;
    run(2);

    // Basic latency: D=3 ms at 4 ticks/ms -> 12 edges.
    start_ch(0, 3, 0);
    s = edge_no;
    chk("t1_busy_rise", longint'(tif.busy[0]), 1);
    run(12);
    chk("t1_latency", last_done_edge[0] - s, 12);
    chk("t1_busy_fall", longint'(tif.busy[0]), 0);
    tick();
    chk("t1_done_single", longint'(tif.done[0]), 0);

    // Two channels overlapping, seconds vs milliseconds.
    dc0 = done_cnt[0]; dc1 = done_cnt[1]; dc2 = done_cnt[2]; dc3 = done_cnt[3];
    start_ch(1, 2, 1);
    s = edge_no;
    tick();
    start_ch(2, 1, 0);
    run(8000);
    chk("t2_ch2_latency", last_done_edge[2] - s, 6);
    chk("t2_ch1_latency", last_done_edge[1] - s, 8000);
    chk("t2_ch1_count", done_cnt[1] - dc1, 1);
    chk("t2_ch2_count", done_cnt[2] - dc2, 1);
    chk("t2_no_crosstalk", (done_cnt[0] - dc0) + (done_cnt[3] - dc3), 0);
    run(2);

    // Zero delay and invalid unit.
    start_ch(0, 0, 2);
    s = edge_no;
    chk("t3_zero_busy", longint'(tif.busy[0]), 0);
    tick();
    chk("t3_zero_latency", last_done_edge[0] - s, 1);
    start_ch(3, 5, 6);
    chk("t3_err_pulse", longint'(tif.err[3]), 1);
    chk("t3_err_busy", longint'(tif.busy[3]), 0);
    tick();
    chk("t3_err_clear", longint'(tif.err[3]), 0);

    // Abort mid-run, and abort together with start on an idle channel.
    start_ch(0, 3, 0);
    dc0 = done_cnt[0];
    run(4);
    tif.abort[0] = 1'b1;
    tick();
    tif.abort[0] = 1'b0;
    chk("t4_abort_busy", longint'(tif.busy[0]), 0);
    set_ch(1, 3, 0);
    tif.start[1] = 1'b1;
    tif.abort[1] = 1'b1;
    tick();
    tif.start[1] = 1'b0;
    tif.abort[1] = 1'b0;
    chk("t4_abort_start_busy", longint'(tif.busy[1]), 0);
    chk("t4_abort_start_err", longint'(tif.err[1]), 0);
    run(14);
    chk("t4_no_done", done_cnt[0] - dc0, 0);

    // Pause for 5 edges mid-run, with an ignored restart while paused.
    dc0 = done_cnt[0];
    start_ch(0, 3, 0);
    s = edge_no;
    run(3);
    tif.pause = 1'b1;
    run(2);
    set_ch(0, 1, 0);
    tif.start[0] = 1'b1;
    tick();
    tif.start[0] = 1'b0;
    run(2);
    tif.pause = 1'b0;
    run(12);
    chk("t5_pause_latency", last_done_edge[0] - s, 17);
    chk("t5_pause_count", done_cnt[0] - dc0, 1);

    // Reset mid-run cancels, then a fresh start behaves normally.
    dc0 = done_cnt[0];
    start_ch(0, 3, 0);
    run(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", longint'(tif.busy), 0);
    chk("t6_rst_done", longint'(tif.done), 0);
    run(12);
    chk("t6_rst_no_done", done_cnt[0] - dc0, 0);
    start_ch(0, 3, 0);
    s2 = edge_no;
    run(13);
    chk("t6_fresh_latency", last_done_edge[0] - s2, 12);

    // Random traffic on all channels; the per-cycle compare carries the checking.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        int r;
        r = int'($urandom_range(0, 15));
        if (r <= 9)       set_ch(ch, int'($urandom_range(0, 7)), 0);
        else if (r <= 13) set_ch(ch, int'($urandom_range(0, 63)), r - 9);
        else              set_ch(ch, int'($urandom_range(0, 63)), int'($urandom_range(5, 7)));
        tif.start[ch] = ($urandom_range(0, 7) == 0);
        tif.abort[ch] = ($urandom_range(0, 39) == 0);
      end
      tif.pause = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst       = 1'b0;
    tif.start = '0;
    tif.abort = '0;
    tif.pause = 1'b0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
